// File: rtl/seq_match.sv
// Sequence playback and key-entry checker: latches a symbol sequence on start,
// shows a growing prefix each round, and verifies the player's keys against it.
module seq_match #(
    parameter int SYMS        = 9,
    parameter int SHOW_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000,
    parameter int TIMEOUT     = 250000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2*SYMS-1:0] seq_in,
    input  logic              key_valid,
    input  logic [1:0]        key_sym,
    output logic              show_valid,
    output logic [1:0]        show_sym,
    output logic              busy,
    output logic [3:0]        level,
    output logic              pass,
    output logic              fail
);

    localparam int MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_SG > TIMEOUT) ? MAX_SG : TIMEOUT;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef enum logic [2:0] {IDLE, SHOW, GAP, INPUT, PASS, FAIL} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [3:0]        idx, idx_d;
    logic [3:0]        level_d;
    logic [2*SYMS-1:0] seq_q, seq_d;
    logic [1:0]        cur_sym;
    logic              last_idx;

    assign cur_sym  = seq_q[{idx, 1'b0} +: 2];
    assign last_idx = (idx == level - 4'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            level <= '0;
            seq_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            level <= level_d;
            seq_q <= seq_d;
        end
    end

    // The single cycle counter restarts from zero whenever the state changes.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        idx_d   = idx;
        level_d = level;
        seq_d   = seq_q;
        case (state)
            IDLE, PASS, FAIL: begin
                cnt_d = '0;
                if (start) begin
                    seq_d   = seq_in;
                    level_d = 4'd1;
                    idx_d   = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt == CW'(SHOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = INPUT;
                    end else begin
                        idx_d   = idx + 4'd1;
                        state_d = SHOW;
                    end
                end
            end
            INPUT: begin
                // A key on the expiry cycle takes priority over the timeout.
                if (key_valid) begin
                    cnt_d = '0;
                    if (key_sym != cur_sym) begin
                        state_d = FAIL;
                    end else if (!last_idx) begin
                        idx_d = idx + 4'd1;
                    end else if (level == 4'(SYMS)) begin
                        state_d = PASS;
                    end else begin
                        level_d = level + 4'd1;
                        idx_d   = '0;
                        state_d = SHOW;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = FAIL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign show_valid = (state == SHOW);
    assign show_sym   = (state == SHOW) ? cur_sym : 2'd0;
    assign busy       = (state == SHOW) || (state == GAP) || (state == INPUT);
    assign pass       = (state == PASS);
    assign fail       = (state == FAIL);

endmodule
